// File: rtl/top_stream_driver_pkg.sv
// -----------------------------------------------------------------------------
// top_stream_driver_pkg
//   Shared constants and types for the stream driver that feeds the
//   y = a*b*cos(c)/(a+d) pipeline.
//
//   OPW        operand width
//   YW         result width {sign, magnitude}
//   SEQW       sequence number width
//   PIPE_LAT   cycles from the accepting edge to the edge that captures dut_y
//   D_INIT_CYC cycles the pipeline needs for its d-accumulator init after reset
//   RES_DEPTH  result FIFO depth (also the total credit limit)
//   result_t   one buffered result: {seq, y}
// -----------------------------------------------------------------------------
package top_stream_driver_pkg;

    localparam int OPW        = 12;
    localparam int YW         = 13;
    localparam int SEQW       = 8;
    localparam int PIPE_LAT   = 18;
    localparam int D_INIT_CYC = 13;
    localparam int RES_DEPTH  = 4;

    typedef struct packed {
        logic [SEQW-1:0] seq;
        logic [YW-1:0]   y;
    } result_t;

    // Sequence numbers wrap naturally 255 -> 0.
    function automatic logic [SEQW-1:0] seq_next(input logic [SEQW-1:0] s);
        return s + 8'd1;
    endfunction

endpackage

// File: rtl/top_stream_driver_result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
//   First-word fall-through FIFO holding result_t entries.
//
//   clk, rst    clock, synchronous active-high reset (pointers/count only)
//   push        write push_data this cycle (caller guarantees not full)
//   push_data   entry to write
//   pop_req     downstream ready; a pop happens only when valid is also high
//   valid       FIFO not empty
//   head        entry at the read pointer, forced to zero while empty
//   count       number of stored entries
// -----------------------------------------------------------------------------
module result_fifo
    import top_stream_driver_pkg::*;
#(
    parameter int DEPTH = RES_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  result_t       push_data,
    input  logic          pop_req,
    output logic          valid,
    output result_t       head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    result_t       mem_q [DEPTH];
    logic          do_pop;

    // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign valid  = (count_q != '0);
    assign do_pop = valid && pop_req;   // pop on empty is ignored
    assign count  = count_q;
    assign head   = valid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            unique case ({push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;  // idle, or push+pop leaves the count alone
            endcase
        end
    end

    // Storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/top_stream_driver.sv
// -----------------------------------------------------------------------------
// top_stream_driver
//   Feeds operand tuples (a, b, c) into the fixed-latency y pipeline and
//   collects its results in order.
//
//   clk, rst            clock, synchronous active-high reset
//   cfg_e               e operand, sampled while rst=1 and held afterwards
//   s_valid/s_ready     operand stream handshake
//   s_a, s_b, s_c       operands
//   dut_a/b/c/e         registered drive to the pipeline inputs
//   dut_y               pipeline result {sign, magnitude}
//   m_valid/m_ready     result stream handshake
//   m_y, m_idx          result and its sequence number at the FIFO head
//   busy                anything in flight or buffered
//
// Handshake: on both streams a transfer happens at a rising edge where
// valid and ready are both high. Ready never depends on the same-cycle
// valid; s_ready comes from registered state only. m_valid stays high
// until the head entry is taken.
//
// Flow control: every accepted tuple takes one credit that it keeps until
// its result leaves the FIFO. With DEPTH credits, a captured result always
// finds a free FIFO slot, so nothing is ever dropped.
// -----------------------------------------------------------------------------
module top_stream_driver
    import top_stream_driver_pkg::*;
#(
    parameter int LAT      = PIPE_LAT,
    parameter int INIT_CYC = D_INIT_CYC,
    parameter int DEPTH    = RES_DEPTH,
    parameter int W        = OPW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] cfg_e,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_a,
    input  logic [W-1:0] s_b,
    input  logic [W-1:0] s_c,
    output logic [W-1:0] dut_a,
    output logic [W-1:0] dut_b,
    output logic [W-1:0] dut_c,
    output logic [W-1:0] dut_e,
    input  logic [W:0]   dut_y,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W:0]   m_y,
    output logic [7:0]   m_idx,
    output logic         busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(INIT_CYC + 1);

    logic [IW-1:0]   init_cnt_q;
    logic            init_done;
    logic [LAT-1:0]  tag_q;
    logic [SEQW-1:0] seq_line_q [LAT];
    logic [CW-1:0]   inflight_q;
    logic [SEQW-1:0] issue_seq_q;
    logic [SEQW-1:0] rslt_seq_q;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credits_used;
    logic            accept;
    logic            capture;
    result_t         push_entry;
    result_t         head_entry;

    // ---------------------------------------------------------------- credit
    assign init_done = (init_cnt_q == IW'(INIT_CYC));

    always_comb begin
        credits_used = {1'b0, inflight_q} + {1'b0, fifo_count};
        s_ready      = init_done && (credits_used < (CW + 1)'(DEPTH));
    end

    assign accept  = s_valid && s_ready;
    // A tag leaving the last stage marks the edge where dut_y belongs to it.
    assign capture = tag_q[LAT-1];

    // ---------------------------------------------------- control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_q  <= '0;
            tag_q       <= '0;
            inflight_q  <= '0;
            issue_seq_q <= '0;
            rslt_seq_q  <= '0;
            dut_a       <= '0;
            dut_b       <= '0;
            dut_c       <= '0;
        end else begin
            if (!init_done) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end

            // Bubbles keep the last operands on the pipeline inputs.
            if (accept) begin
                dut_a       <= s_a;
                dut_b       <= s_b;
                dut_c       <= s_c;
                issue_seq_q <= seq_next(issue_seq_q);
            end

            tag_q <= {tag_q[LAT-2:0], accept};

            if (capture) begin
                rslt_seq_q <= seq_next(rslt_seq_q);
            end

            unique case ({accept, capture})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: ;  // accept+capture swap one credit for another
            endcase
        end
    end

    // e is a per-run constant for the pipeline; it only moves during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_e <= cfg_e;
        end
    end

    // Sequence numbers ride alongside the tags; only stages holding a 1 tag
    // are ever looked at, so this line needs no reset.
    always_ff @(posedge clk) begin
        seq_line_q[0] <= issue_seq_q;
        for (int i = 1; i < LAT; i++) begin
            seq_line_q[i] <= seq_line_q[i-1];
        end
    end

    // Results return in issue order, so the carried tag and the running
    // result count must agree at every capture.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            assert (seq_line_q[LAT-1] == rslt_seq_q);
        end
    end

    // ------------------------------------------------------------ result FIFO
    assign push_entry.seq = seq_line_q[LAT-1];
    assign push_entry.y   = dut_y;

    result_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (push_entry),
        .pop_req   (m_ready),
        .valid     (m_valid),
        .head      (head_entry),
        .count     (fifo_count)
    );

    assign m_y   = head_entry.y;
    assign m_idx = head_entry.seq;
    assign busy  = (inflight_q != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_top_stream_driver.sv
// -----------------------------------------------------------------------------
// tb_top_stream_driver
//   Directed bench for top_stream_driver with a stub pipeline whose result
//   is {1'b0, a ^ b}, captured LAT edges after the accepting edge.
// -----------------------------------------------------------------------------
module tb_top_stream_driver;

    localparam int LAT   = 18;
    localparam int DEPTH = 4;
    localparam int W     = 12;

    // ------------------------------------------------------ clock and reset
    logic         clk;
    logic         rst;
    logic [W-1:0] cfg_e;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_a, s_b, s_c;
    logic [W-1:0] dut_a, dut_b, dut_c, dut_e;
    logic [W:0]   dut_y;
    logic         m_valid;
    logic         m_ready;
    logic [W:0]   m_y;
    logic [7:0]   m_idx;
    logic         busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    top_stream_driver dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_e   (cfg_e),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_a     (s_a),
        .s_b     (s_b),
        .s_c     (s_c),
        .dut_a   (dut_a),
        .dut_b   (dut_b),
        .dut_c   (dut_c),
        .dut_e   (dut_e),
        .dut_y   (dut_y),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_y     (m_y),
        .m_idx   (m_idx),
        .busy    (busy)
    );

    // Stub pipeline: LAT-1 stages after the dut_a/dut_b registers, so the
    // value launched at edge k is on dut_y when edge k+LAT captures it.
    logic [W-1:0] stub_q [LAT-1];
    always @(posedge clk) begin
        stub_q[0] <= dut_a ^ dut_b;
        for (int i = 1; i < LAT - 1; i++) begin
            stub_q[i] <= stub_q[i-1];
        end
    end
    assign dut_y = {1'b0, stub_q[LAT-2]};

    // ------------------------------------------------------------ scoreboard
    int          checks;
    int          errors;
    int          n_acc;
    int          ovf_cnt;
    logic [7:0]  exp_idx;
    logic [20:0] exp_q[$];   // {idx, y}

    // A result captured while the FIFO is already full would be lost.
    always @(negedge clk) begin
        if (!rst && dut.capture && (int'(dut.fifo_count) == DEPTH)) begin
            ovf_cnt++;
        end
    end

    // --------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one edge, recording an accepted tuple in the expected queue
    // and returning the result taken downstream at that edge.
    task automatic tick_track(output bit popped, output logic [7:0] gi,
                              output logic [12:0] gy);
        popped = 1'b0;
        gi     = '0;
        gy     = '0;
        if (s_valid && s_ready) begin
            exp_q.push_back({exp_idx, 1'b0, s_a ^ s_b});
            exp_idx = exp_idx + 8'd1;
            n_acc++;
        end
        if (m_valid && m_ready) begin
            popped = 1'b1;
            gi     = m_idx;
            gy     = m_y;
        end
        tick();
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        int n;
        rst = 1'b1; cfg_e = 12'h0A5; s_valid = 1'b0; m_ready = 1'b0;
        s_a = '0; s_b = '0; s_c = '0;
        repeat (3) tick();
        checks++;
        if ({s_ready, m_valid, m_y, m_idx, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b mv=%b y=%h idx=%h busy=%b, need all 0",
                     s_ready, m_valid, m_y, m_idx, busy);
        end
        checks++;
        if ({dut_a, dut_b, dut_c} !== '0) begin
            errors++;
            $display("FAIL reset_dut_abc: got %h %h %h, need 0", dut_a, dut_b, dut_c);
        end
        rst = 1'b0;
        cfg_e = 12'h3C3;
        s_valid = 1'b1; s_a = 12'h111; s_b = 12'h222; s_c = 12'h333;
        n = 0;
        while (!s_ready && n < 40) begin
            tick();
            n++;
        end
        s_valid = 1'b0;
        checks++;
        if (n != 13) begin
            errors++;
            $display("FAIL init_window: s_ready rose after %0d cycles, need 13", n);
        end
        checks++;
        if (dut_e !== 12'h0A5) begin
            errors++;
            $display("FAIL dut_e_hold: got %h, need 0a5", dut_e);
        end
        checks++;
        if (busy !== 1'b0 || dut_a !== 12'h000) begin
            errors++;
            $display("FAIL init_no_accept: busy=%b dut_a=%h, need 0 and 000", busy, dut_a);
        end
        exp_idx = 8'd0;
    endtask

    task automatic test_single();
        int n;
        s_valid = 1'b1; s_a = 12'h123; s_b = 12'h0F0; s_c = 12'h055;
        tick();                          // accepting edge k
        s_valid = 1'b0;
        checks++;
        if ({dut_a, dut_b, dut_c} !== {12'h123, 12'h0F0, 12'h055}) begin
            errors++;
            $display("FAIL single_drive: got %h %h %h, need 123 0f0 055", dut_a, dut_b, dut_c);
        end
        n = 0;
        while (!m_valid && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 18) begin
            errors++;
            $display("FAIL single_latency: m_valid after %0d edges, need 18", n);
        end
        checks++;
        if (m_y !== 13'h1D3) begin  // 0x123 ^ 0x0F0
            errors++;
            $display("FAIL single_y: got %h, need 1d3", m_y);
        end
        checks++;
        if (m_idx !== 8'd0) begin
            errors++;
            $display("FAIL single_idx: got %0d, need 0", m_idx);
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: m_valid=%b busy=%b, need 0 0", m_valid, busy);
        end
        exp_idx = 8'd1;
    endtask

    task automatic test_backpressure();
        logic [11:0] a_tab [6] = '{12'h001, 12'h0FF, 12'hABC, 12'h800, 12'h7FF, 12'h3C3};
        logic [11:0] b_tab [6] = '{12'h010, 12'hF00, 12'h0C0, 12'h801, 12'h000, 12'hFFF};
        bit          pp;
        logic [7:0]  gi;
        logic [12:0] gy;
        logic [20:0] ex;
        n_acc = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1; s_a = a_tab[i]; s_b = b_tab[i]; s_c = 12'(i);
            tick_track(pp, gi, gy);
        end
        repeat (30) tick_track(pp, gi, gy);
        checks++;
        if (n_acc != 4) begin
            errors++;
            $display("FAIL bp_accepts: got %0d accepted, need 4", n_acc);
        end
        checks++;
        if ({s_ready, m_valid, busy} !== 3'b011) begin
            errors++;
            $display("FAIL bp_full: rdy=%b mv=%b busy=%b, need 0 1 1", s_ready, m_valid, busy);
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_ready = 1'b1;
            tick_track(pp, gi, gy);
            checks++;
            if (!pp || exp_q.size() == 0) begin
                errors++;
                $display("FAIL bp_pop%0d: popped=%b queued=%0d, need pop", i, pp, exp_q.size());
            end else begin
                ex = exp_q.pop_front();
                if ({gi, gy} !== ex) begin
                    errors++;
                    $display("FAIL bp_order%0d: got idx=%0d y=%h, need idx=%0d y=%h",
                             i, gi, gy, ex[20:13], ex[12:0]);
                end
            end
        end
        m_ready = 1'b0;
        checks++;
        if ({s_ready, m_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL bp_release: rdy=%b mv=%b busy=%b, need 1 0 0", s_ready, m_valid, busy);
        end
    endtask

    // Continuous offer with m_ready high: 4 accepts fill the credits, the
    // first result lands at edge 18 and pops at 19, credits free up from
    // edge 19 on, so the accept pattern repeats every 20 edges.
    task automatic test_back_to_back();
        bit          pp;
        logic [7:0]  gi;
        logic [12:0] gy;
        logic [20:0] ex;
        int          n;
        n_acc = 0;
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int e = 0; e < 80; e++) begin
            s_a = 12'($urandom_range(0, 4095));
            s_b = 12'($urandom_range(0, 4095));
            checks++;
            if (s_ready !== ((e % 20) < 4)) begin
                errors++;
                $display("FAIL b2b_ready_e%0d: got %b, need %b", e, s_ready, (e % 20) < 4);
            end
            tick_track(pp, gi, gy);
            if (pp) begin
                checks++;
                ex = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                if ({gi, gy} !== ex) begin
                    errors++;
                    $display("FAIL b2b_result: got idx=%0d y=%h, need idx=%0d y=%h",
                             gi, gy, ex[20:13], ex[12:0]);
                end
            end
        end
        s_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick_track(pp, gi, gy);
            n++;
            if (pp) begin
                checks++;
                ex = exp_q.pop_front();
                if ({gi, gy} !== ex) begin
                    errors++;
                    $display("FAIL b2b_drain: got idx=%0d y=%h, need idx=%0d y=%h",
                             gi, gy, ex[20:13], ex[12:0]);
                end
            end
        end
        checks++;
        if (n_acc != 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: accepted=%0d left=%0d, need 16 and 0", n_acc, exp_q.size());
        end
    endtask

    task automatic test_stream();
        bit          pp;
        bit          wrapped;
        logic [7:0]  gi;
        logic [7:0]  prev_idx;
        logic [12:0] gy;
        logic [20:0] ex;
        int          cyc;
        n_acc = 0;
        wrapped = 1'b0;
        prev_idx = 8'd0;
        m_ready = 1'b1;
        cyc = 0;
        while ((n_acc < 300 || exp_q.size() != 0) && cyc < 10000) begin
            s_valid = (n_acc < 300) && ($urandom_range(0, 3) != 0);
            s_a = 12'($urandom_range(0, 4095));
            s_b = 12'($urandom_range(0, 4095));
            s_c = 12'($urandom_range(0, 4095));
            tick_track(pp, gi, gy);
            cyc++;
            if (pp) begin
                checks++;
                ex = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                if ({gi, gy} !== ex) begin
                    errors++;
                    $display("FAIL stream_result: got idx=%0d y=%h, need idx=%0d y=%h",
                             gi, gy, ex[20:13], ex[12:0]);
                end
                if (prev_idx == 8'd255 && gi == 8'd0) wrapped = 1'b1;
                prev_idx = gi;
            end
        end
        s_valid = 1'b0;
        checks++;
        if (n_acc != 300 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_done: accepted=%0d left=%0d, need 300 and 0", n_acc, exp_q.size());
        end
        checks++;
        if (!wrapped) begin
            errors++;
            $display("FAIL stream_wrap: idx 255->0 seen=%b, need 1", wrapped);
        end
    endtask

    // Two results buffered and two in flight (four credits total) when rst
    // pulses for one edge; none of them may ever come out.
    task automatic test_reset_mid();
        bit          pp;
        logic [7:0]  gi;
        logic [12:0] gy;
        logic [20:0] ex;
        int          n;
        int          stale;
        m_ready = 1'b0;
        s_valid = 1'b1; s_a = 12'h0AA; s_b = 12'h055;
        repeat (2) tick_track(pp, gi, gy);
        s_valid = 1'b0;
        repeat (20) tick_track(pp, gi, gy);
        s_valid = 1'b1; s_a = 12'h777; s_b = 12'h111;
        repeat (2) tick_track(pp, gi, gy);
        s_valid = 1'b0;
        repeat (3) tick_track(pp, gi, gy);
        checks++;
        if ({m_valid, busy, s_ready} !== 3'b110) begin
            errors++;
            $display("FAIL mid_setup: mv=%b busy=%b rdy=%b, need 1 1 0", m_valid, busy, s_ready);
        end
        cfg_e = 12'h5A5;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cfg_e = 12'h111;
        exp_q.delete();
        exp_idx = 8'd0;
        checks++;
        if ({m_valid, busy, s_ready, m_y, m_idx} !== '0) begin
            errors++;
            $display("FAIL mid_clear: mv=%b busy=%b rdy=%b y=%h idx=%h, need all 0",
                     m_valid, busy, s_ready, m_y, m_idx);
        end
        checks++;
        if (dut_e !== 12'h5A5 || dut_a !== 12'h000) begin
            errors++;
            $display("FAIL mid_regs: dut_e=%h dut_a=%h, need 5a5 000", dut_e, dut_a);
        end
        m_ready = 1'b1;
        stale = 0;
        n = 0;
        while (!s_ready && n < 40) begin
            if (m_valid) stale++;
            tick();
            n++;
        end
        checks++;
        if (n != 13) begin
            errors++;
            $display("FAIL mid_init: s_ready rose after %0d cycles, need 13", n);
        end
        repeat (30) begin
            if (m_valid) stale++;
            tick();
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL mid_stale: %0d stale result cycles, need 0", stale);
        end
        s_valid = 1'b1; s_a = 12'h00F; s_b = 12'h0F0;
        tick_track(pp, gi, gy);
        s_valid = 1'b0;
        n = 0;
        pp = 1'b0;
        while (!pp && n < 40) begin
            tick_track(pp, gi, gy);
            n++;
        end
        checks++;
        if (!pp || exp_q.size() == 0) begin
            errors++;
            $display("FAIL mid_first: popped=%b queued=%0d, need a result", pp, exp_q.size());
        end else begin
            ex = exp_q.pop_front();
            if ({gi, gy} !== ex || ex !== {8'd0, 13'h0FF}) begin
                errors++;
                $display("FAIL mid_first: got idx=%0d y=%h, need idx=0 y=0ff", gi, gy);
            end
        end
        checks++;
        if (dut_e !== 12'h5A5) begin
            errors++;
            $display("FAIL mid_e_hold: got %h, need 5a5", dut_e);
        end
    endtask

    // ---------------------------------------------------------------- report
    initial begin
        checks  = 0;
        errors  = 0;
        n_acc   = 0;
        ovf_cnt = 0;
        exp_idx = 8'd0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        checks++;
        if (ovf_cnt != 0) begin
            errors++;
            $display("FAIL fifo_overflow: %0d pushes into a full FIFO, need 0", ovf_cnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
